// File: rtl/processor_nios_ii_cpu_debug_host_driver.sv
// Initiator end of the 2-bit-IR virtual JTAG link into the CPU debug slave.
// Runs one (IR, DR) command through UIR/CDR/SDR/UDR/RTI with a clk-derived tck data signal.
module processor_nios_ii_cpu_debug_host_driver #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(DR_WIDTH + 1);
    localparam int RTI_W = $clog2(RTI_CYCLES + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]          state;
    logic [DIV_W-1:0]    div_cnt;
    logic                tck;
    logic [BIT_W-1:0]    bit_cnt;
    logic [RTI_W-1:0]    rti_cnt;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] dr_sr;
    logic                tdi;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;

    logic active;
    logic half_end;
    logic tck_rise;
    logic tck_fall;

    always_comb begin
        active   = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                   (state == S_UDR) || (state == S_RTI);
        half_end = (div_cnt == DIV_W'(TCK_DIV - 1));
        tck_rise = active && half_end && !tck;
        tck_fall = active && half_end && tck;
    end

    // State flags, ir_in and tdi only move on the clk edge that also drops tck,
    // so the slave always sees them settled before its next rising tck.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            tck      <= 1'b0;
            bit_cnt  <= '0;
            rti_cnt  <= '0;
            ir_q     <= '0;
            dr_sr    <= '0;
            tdi      <= 1'b0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ir_q    <= cmd_ir;
                        dr_sr   <= cmd_dr;
                        div_cnt <= '0;
                        tck     <= 1'b0;
                        bit_cnt <= '0;
                        rti_cnt <= '0;
                        state   <= S_UIR;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        tck     <= ~tck;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end

                    if (tck_rise) begin
                        if (state == S_UIR) begin
                            rsp_ir_q <= vji_ir_out;
                        end
                        if (state == S_SDR) begin
                            rsp_dr_q <= {vji_tdo, rsp_dr_q[DR_WIDTH-1:1]};
                        end
                    end

                    if (tck_fall) begin
                        case (state)
                            S_UIR: state <= S_CDR;
                            S_CDR: begin
                                state <= S_SDR;
                                tdi   <= dr_sr[0];
                                dr_sr <= dr_sr >> 1;
                            end
                            S_SDR: begin
                                if (bit_cnt == BIT_W'(DR_WIDTH - 1)) begin
                                    state <= S_UDR;
                                    tdi   <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                    tdi     <= dr_sr[0];
                                    dr_sr   <= dr_sr >> 1;
                                end
                            end
                            S_UDR: state <= S_RTI;
                            S_RTI: begin
                                if (rti_cnt == RTI_W'(RTI_CYCLES - 1)) begin
                                    state <= S_RESP;
                                end else begin
                                    rti_cnt <= rti_cnt + RTI_W'(1);
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign cmd_ready  = (state == S_IDLE) && !reset;
    assign busy       = (state != S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_q;

    assign vji_tck    = tck;
    assign vji_tdi    = tdi;
    assign vji_ir_in  = active ? ir_q : '0;
    assign vji_uir    = (state == S_UIR);
    assign vji_cdr    = (state == S_CDR);
    assign vji_sdr    = (state == S_SDR);
    assign vji_udr    = (state == S_UDR);
    assign vji_rti    = (state == S_RTI);

endmodule

// File: tb/tb_processor_nios_ii_cpu_debug_host_driver.sv
// Scoreboard bench for the virtual JTAG host driver: default and fast-tck instances.
module tb_processor_nios_ii_cpu_debug_host_driver;

    localparam int LAT_A = 2 * 2 * (38 + 3 + 3) + 1;
    localparam int LAT_B = 2 * 1 * (38 + 3 + 1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_dr, rsp_dr;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic        tdo_one;

    logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
    logic [1:0]  cmd_ir_b, rsp_ir_out_b, vji_ir_in_b, vji_ir_out_b;
    logic [37:0] cmd_dr_b, rsp_dr_b;
    logic        vji_tck_b, vji_tdi_b, vji_tdo_b;
    logic        vji_uir_b, vji_cdr_b, vji_sdr_b, vji_udr_b, vji_rti_b;

    assign vji_tdo   = tdo_one ? 1'b1 : vji_tdi;
    assign vji_tdo_b = vji_tdi_b;

    processor_nios_ii_cpu_debug_host_driver u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    processor_nios_ii_cpu_debug_host_driver #(
        .DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .rsp_ir_out(rsp_ir_out_b),
        .busy(busy_b), .vji_tck(vji_tck_b), .vji_tdi(vji_tdi_b), .vji_tdo(vji_tdo_b),
        .vji_ir_in(vji_ir_in_b), .vji_ir_out(vji_ir_out_b),
        .vji_uir(vji_uir_b), .vji_cdr(vji_cdr_b), .vji_sdr(vji_sdr_b), .vji_udr(vji_udr_b), .vji_rti(vji_rti_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor on the default instance; main code only reads its counters.
    logic       mon_en = 1'b0;
    logic [1:0] cur_ir = 2'b00;
    logic [4:0] flags, pflags;
    logic [4:0] flags_b;
    logic       ptck, ptdi;
    logic [1:0] pir;
    int n_onehot = 0, n_chg = 0, n_tdi = 0, n_ir = 0, n_onehot_b = 0;
    int c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, c_rti = 0;

    assign flags   = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
    assign flags_b = {vji_uir_b, vji_cdr_b, vji_sdr_b, vji_udr_b, vji_rti_b};

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(flags) > 1) n_onehot <= n_onehot + 1;
            if ($countones(flags_b) > 1) n_onehot_b <= n_onehot_b + 1;
            if ((flags != pflags || vji_tdi != ptdi || vji_ir_in != pir) &&
                !(vji_tck == 1'b0 && (ptck == 1'b1 || pflags == 5'd0)))
                n_chg <= n_chg + 1;
            if (vji_tdi && !vji_sdr) n_tdi <= n_tdi + 1;
            if (((flags != 5'd0) ? cur_ir : 2'b00) != vji_ir_in) n_ir <= n_ir + 1;
        end
        pflags <= flags;
        ptck   <= vji_tck;
        ptdi   <= vji_tdi;
        pir    <= vji_ir_in;
        c_uir  <= c_uir + int'(vji_uir);
        c_cdr  <= c_cdr + int'(vji_cdr);
        c_sdr  <= c_sdr + int'(vji_sdr);
        c_udr  <= c_udr + int'(vji_udr);
        c_rti  <= c_rti + int'(vji_rti);
    end

    typedef struct {
        logic [37:0] dr;
        logic [1:0]  ir;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int   last_acc;

    task automatic issue(input logic [1:0] ir, input logic [37:0] dr,
                         input logic [37:0] edr, input logic [1:0] eir, input bit push);
        bit   got = 0;
        exp_t e;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("accept_timeout", 0, 1);
        last_acc = cyc;
        cur_ir   = ir;
        if (push) begin
            e.dr  = edr;
            e.ir  = eir;
            e.lat = LAT_A;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit   seen = 0;
        exp_t e;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("rsp_timeout", 0, 1);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!seen) return;
        check("latency", 64'(cyc - last_acc), 64'(e.lat));
        check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        check("rsp_ir_out", 64'(rsp_ir_out), 64'(e.ir));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_clear", 64'(rsp_valid), 0);
        check("idle_ready", 64'(cmd_ready), 1);
        check("idle_busy", 64'(busy), 0);
    endtask

    initial begin
        int s_uir, s_cdr, s_sdr, s_udr, s_rti;
        int vcnt;
        int acc_b;
        bit seen_b;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
        vji_ir_out = 2'b00; tdo_one = 1'b0;
        cmd_valid_b = 1'b0; cmd_ir_b = '0; cmd_dr_b = '0; rsp_ready_b = 1'b0;
        vji_ir_out_b = 2'b01;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_vji", 64'({vji_tck, vji_tdi, vji_ir_in, flags}), 0);
        check("rst_rsp", 64'({rsp_dr, rsp_ir_out}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("first_idle_ready", 64'(cmd_ready), 1);
        mon_en = 1'b1;

        // Loopback transfer plus per-state durations
        vji_ir_out = 2'b01;
        s_uir = c_uir; s_cdr = c_cdr; s_sdr = c_sdr; s_udr = c_udr; s_rti = c_rti;
        issue(2'b01, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 2'b01, 1'b1);
        wait_rsp();
        check("len_uir", 64'(c_uir - s_uir), 4);
        check("len_cdr", 64'(c_cdr - s_cdr), 4);
        check("len_sdr", 64'(c_sdr - s_sdr), 152);
        check("len_udr", 64'(c_udr - s_udr), 4);
        check("len_rti", 64'(c_rti - s_rti), 12);
        handshake();

        // tdo tied high, distinct IR status
        tdo_one = 1'b1;
        vji_ir_out = 2'b10;
        issue(2'b10, 38'h01_2345_6789, 38'h3F_FFFF_FFFF, 2'b10, 1'b1);
        wait_rsp();
        handshake();
        tdo_one = 1'b0;
        check("mon_onehot", 64'(n_onehot), 0);
        check("mon_edge", 64'(n_chg), 0);
        check("mon_tdi_idle", 64'(n_tdi), 0);
        check("mon_ir_in", 64'(n_ir), 0);

        // Reset during SDR bit 20
        vji_ir_out = 2'b11;
        issue(2'b11, 38'h15_0F0F_3C3C, 38'h0, 2'b00, 1'b0);
        repeat (88) @(negedge clk);
        check("at_sdr_bit20", 64'(vji_sdr), 1);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_vji", 64'({vji_tck, vji_tdi, vji_ir_in, flags}), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_rsp", 64'(rsp_valid), 0);
        check("abort_ready", 64'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", 64'(cmd_ready), 1);
        vcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) vcnt++;
            @(negedge clk);
        end
        check("abort_no_rsp", 64'(vcnt), 0);
        mon_en = 1'b1;
        issue(2'b11, 38'h15_0F0F_3C3C, 38'h15_0F0F_3C3C, 2'b11, 1'b1);
        wait_rsp();
        handshake();

        // Back-pressure on the response with a command waiting
        vji_ir_out = 2'b01;
        issue(2'b00, 38'h33_CCCC_0F0F, 38'h33_CCCC_0F0F, 2'b01, 1'b1);
        wait_rsp();
        cmd_ir = 2'b01;
        cmd_dr = 38'h0A_BCDE_F012;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_dr", 64'(rsp_dr), 64'(38'h33_CCCC_0F0F));
            check("hold_ir", 64'(rsp_ir_out), 64'(2'b01));
            check("hold_valid", 64'(rsp_valid), 1);
            check("hold_ready", 64'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        check("hs_cmd_blocked", 64'(cmd_ready), 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_rsp_clear", 64'(rsp_valid), 0);
        issue(2'b01, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, 2'b01, 1'b1);
        check("hs_next_busy", 64'(busy), 1);
        wait_rsp();
        handshake();
        check("mon_onehot2", 64'(n_onehot), 0);
        check("mon_edge2", 64'(n_chg), 0);
        check("mon_tdi_idle2", 64'(n_tdi), 0);
        check("mon_ir_in2", 64'(n_ir), 0);

        // Fast instance: TCK_DIV=1, RTI_CYCLES=1
        cmd_ir_b = 2'b10;
        cmd_dr_b = 38'h25_A5A5_5A5A;
        cmd_valid_b = 1'b1;
        check("b_ready", 64'(cmd_ready_b), 1);
        acc_b = cyc;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        check("b_tck0", 64'(vji_tck_b), 0);
        check("b_uir", 64'(vji_uir_b), 1);
        check("b_ir_in", 64'(vji_ir_in_b), 64'(2'b10));
        @(negedge clk);
        check("b_tck1", 64'(vji_tck_b), 1);
        @(negedge clk);
        check("b_tck2", 64'(vji_tck_b), 0);
        check("b_cdr", 64'(vji_cdr_b), 1);
        seen_b = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid_b) begin
                seen_b = 1;
                break;
            end
            @(negedge clk);
        end
        check("b_rsp_seen", 64'(seen_b), 1);
        check("b_latency", 64'(cyc - acc_b), 64'(LAT_B));
        check("b_rsp_dr", 64'(rsp_dr_b), 64'(38'h25_A5A5_5A5A));
        check("b_rsp_ir_out", 64'(rsp_ir_out_b), 64'(2'b01));
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_b = 1'b0;
        check("b_idle", 64'({busy_b, rsp_valid_b}), 0);
        check("b_onehot", 64'(n_onehot_b), 0);

        check("sb_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
